// File: rtl/sram_bank_arbiter_if.sv
// sram_bank_arbiter_if: client request/return bus plus the SRAM bank bus of
// the arbiter. The arbiter connects through the slave modport. The master
// modport is the client side that also models the SRAM banks.
interface sram_bank_arbiter_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int NUM_BANKS   = 2,
  parameter int LOG_BANKS   = 1,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 36
);
  logic [NUM_CLIENTS-1:0]           req;
  logic [NUM_CLIENTS-1:0]           wr;
  logic [NUM_CLIENTS*LOG_BANKS-1:0] bank;
  logic [NUM_CLIENTS*ADDR_W-1:0]    addr;
  logic [NUM_CLIENTS*DATA_W-1:0]    wdata;
  logic [NUM_CLIENTS-1:0]           grant;
  logic [NUM_CLIENTS-1:0]           rvalid;
  logic [NUM_CLIENTS*DATA_W-1:0]    rdata;
  logic [NUM_BANKS-1:0]             mem_cen;
  logic [NUM_BANKS-1:0]             mem_we;
  logic [NUM_BANKS*ADDR_W-1:0]      mem_addr;
  logic [NUM_BANKS*DATA_W-1:0]      mem_wdata;
  logic [NUM_BANKS*DATA_W-1:0]      mem_rdata;

  modport master (
    output req, wr, bank, addr, wdata, mem_rdata,
    input  grant, rvalid, rdata, mem_cen, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, wr, bank, addr, wdata, mem_rdata,
    output grant, rvalid, rdata, mem_cen, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter: N-client, M-bank SRAM arbiter with zero-cycle grants and
// per-bank tag pipelines that route read data back to the issuing client
// READ_LAT cycles after the address cycle.
// Build option: define ARB_ROUND_ROBIN_EN for per-bank round-robin
// arbitration. The default build uses fixed priority, where the lowest
// client index wins.
module sram_bank_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int NUM_BANKS   = 2,
  parameter int LOG_BANKS   = 1,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 36,
  parameter int READ_LAT    = 2
) (
  input logic                clock,
  input logic                reset,
  sram_bank_arbiter_if.slave bus
);
  localparam int CLI_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  logic [NUM_BANKS-1:0][NUM_CLIENTS-1:0]         cand;
  logic [NUM_BANKS-1:0]                          bank_gnt;
  logic [NUM_BANKS-1:0][CLI_W-1:0]               bank_cli;
  logic [NUM_BANKS-1:0][READ_LAT-1:0]            tag_vld_q, tag_vld_d;
  logic [NUM_BANKS-1:0][READ_LAT-1:0][CLI_W-1:0] tag_cli_q, tag_cli_d;
  logic [NUM_CLIENTS*DATA_W-1:0]                 held_q, held_d;
  logic [NUM_CLIENTS*DATA_W-1:0]                 rdata_mux;
`ifdef ARB_ROUND_ROBIN_EN
  logic [NUM_BANKS-1:0][CLI_W-1:0]               last_q, last_d;
  int                                            c_rr;
`endif

  // Candidate matrix: a client competes only for the bank it targets; an
  // out-of-range bank field never matches, and nothing competes in reset.
  always_comb begin
    cand = '0;
    for (int c = 0; c < NUM_CLIENTS; c++) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (!reset && bus.req[c] &&
            (int'(bus.bank[c*LOG_BANKS +: LOG_BANKS]) == b)) begin
          cand[b][c] = 1'b1;
        end
      end
    end
  end

  // Per-bank arbitration: pick one candidate per bank.
  always_comb begin
    bank_gnt = '0;
    bank_cli = '0;
`ifdef ARB_ROUND_ROBIN_EN
    c_rr = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int k = 1; k <= NUM_CLIENTS; k++) begin
        c_rr = (int'(last_q[b]) + k) % NUM_CLIENTS;
        if (!bank_gnt[b] && cand[b][c_rr]) begin
          bank_gnt[b] = 1'b1;
          bank_cli[b] = CLI_W'(c_rr);
        end
      end
    end
`else
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int c = 0; c < NUM_CLIENTS; c++) begin
        if (!bank_gnt[b] && cand[b][c]) begin
          bank_gnt[b] = 1'b1;
          bank_cli[b] = CLI_W'(c);
        end
      end
    end
`endif
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Round-robin pointer moves only when its bank actually grants.
  always_comb begin
    last_d = last_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_gnt[b]) last_d[b] = bank_cli[b];
    end
  end

  // Pointers restart at the last client so client 0 is searched first.
  always_ff @(posedge clock) begin
    if (reset) last_q <= {NUM_BANKS{CLI_W'(NUM_CLIENTS - 1)}};
    else       last_q <= last_d;
  end
`endif

  // Grant vector and bank drive: idle banks are driven to all zeros.
  always_comb begin
    bus.grant     = '0;
    bus.mem_cen   = '0;
    bus.mem_we    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_gnt[b]) begin
        bus.grant[bank_cli[b]]            = 1'b1;
        bus.mem_cen[b]                    = 1'b1;
        bus.mem_we[b]                     = bus.wr[bank_cli[b]];
        bus.mem_addr[b*ADDR_W +: ADDR_W]  = bus.addr[int'(bank_cli[b])*ADDR_W +: ADDR_W];
        bus.mem_wdata[b*DATA_W +: DATA_W] = bus.wdata[int'(bank_cli[b])*DATA_W +: DATA_W];
      end
    end
  end

  // Tag pipeline next state: stage 0 takes granted reads only, the rest shift.
  always_comb begin
    tag_vld_d = '0;
    tag_cli_d = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      tag_vld_d[b][0] = bank_gnt[b] && !bus.wr[bank_cli[b]];
      tag_cli_d[b][0] = bank_cli[b];
      for (int s = 1; s < READ_LAT; s++) begin
        tag_vld_d[b][s] = tag_vld_q[b][s-1];
        tag_cli_d[b][s] = tag_cli_q[b][s-1];
      end
    end
  end

  // Tag valid bits are cleared by reset, so in-flight reads are dropped.
  always_ff @(posedge clock) begin
    if (reset) tag_vld_q <= '0;
    else       tag_vld_q <= tag_vld_d;
  end

  // Tag client indices only matter while the valid bit is set.
  always_ff @(posedge clock) begin
    tag_cli_q <= tag_cli_d;
  end

  // Read return: pass bank data straight through on the return cycle,
  // otherwise present the held copy of each client's last return.
  always_comb begin
    bus.rvalid = '0;
    rdata_mux  = held_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (tag_vld_q[b][READ_LAT-1]) begin
        bus.rvalid[tag_cli_q[b][READ_LAT-1]] = 1'b1;
        rdata_mux[int'(tag_cli_q[b][READ_LAT-1])*DATA_W +: DATA_W] =
          bus.mem_rdata[b*DATA_W +: DATA_W];
      end
    end
    held_d    = rdata_mux;
    bus.rdata = rdata_mux;
    if (reset) begin
      bus.rvalid = '0;
      bus.rdata  = '0;
    end
  end

  // Held read data register, zeroed by reset.
  always_ff @(posedge clock) begin
    if (reset) held_q <= '0;
    else       held_q <= held_d;
  end
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// tb_sram_bank_arbiter: directed bench for sram_bank_arbiter, with a
// queue-based reference model of the arbiter and a small SRAM model
// driving mem_rdata.
module tb_sram_bank_arbiter;
  localparam int N  = 4;
  localparam int M  = 2;
  localparam int LB = 1;
  localparam int AW = 19;
  localparam int DW = 36;
  localparam int L  = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sram_bank_arbiter_if #(.NUM_CLIENTS(N), .NUM_BANKS(M), .LOG_BANKS(LB),
                         .ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_bank_arbiter #(.NUM_CLIENTS(N), .NUM_BANKS(M), .LOG_BANKS(LB),
                      .ADDR_W(AW), .DATA_W(DW), .READ_LAT(L)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int b, input int a);
    return DW'(b) * 36'h1000000 + 36'h1000 + DW'(a);
  endfunction

  // SRAM model (reacts to the bank bus) and a mirror copy kept by the reference model
  logic [DW-1:0] sram   [M][1024];
  logic [DW-1:0] mir    [M][1024];
  logic          slot_v [M][8];
  logic [DW-1:0] slot_d [M][8];

  always_comb begin
    bus.mem_rdata = '0;
    for (int b = 0; b < M; b++)
      bus.mem_rdata[b*DW +: DW] = slot_v[b][cyc%8] ? slot_d[b][cyc%8] : 36'hBADBADBAD;
  end

  initial begin
    forever begin
      @(negedge clock);
      for (int b = 0; b < M; b++) begin
        slot_v[b][(cyc+L)%8] = bus.mem_cen[b] && !bus.mem_we[b];
        slot_d[b][(cyc+L)%8] = sram[b][bus.mem_addr[b*AW +: 10]];
        if (bus.mem_cen[b] && bus.mem_we[b])
          sram[b][bus.mem_addr[b*AW +: 10]] = bus.mem_wdata[b*DW +: DW];
      end
    end
  end

  // Reference model and per-cycle compare
  typedef struct {
    int            due;
    int            cli;
    logic [DW-1:0] data;
  } ret_t;

  ret_t          pend [$];
  int            last_m [M];
  logic [DW-1:0] held_m [N];

  initial begin
    logic [N-1:0]    e_grant, e_rvalid;
    logic [M-1:0]    e_cen, e_we;
    logic [M*AW-1:0] e_addr;
    logic [M*DW-1:0] e_wdata;
    logic [N*DW-1:0] e_rdata;
    ret_t            keep [$];
    int              best, bestd, d;
    for (int b = 0; b < M; b++) last_m[b] = N - 1;
    for (int c = 0; c < N; c++) held_m[c] = '0;
    forever begin
      @(negedge clock);
      e_grant = '0; e_rvalid = '0; e_cen = '0; e_we = '0; e_addr = '0; e_wdata = '0;
      if (reset) begin
        pend.delete();
        for (int b = 0; b < M; b++) last_m[b] = N - 1;
        for (int c = 0; c < N; c++) held_m[c] = '0;
      end else begin
        keep.delete();
        foreach (pend[i]) begin
          if (pend[i].due == cyc) begin
            e_rvalid[pend[i].cli] = 1'b1;
            held_m[pend[i].cli]   = pend[i].data;
          end else begin
            keep.push_back(pend[i]);
          end
        end
        pend = keep;
        for (int b = 0; b < M; b++) begin
          best = -1; bestd = N;
          for (int c = 0; c < N; c++) begin
            if (bus.req[c] && int'(bus.bank[c*LB +: LB]) == b) begin
`ifdef ARB_ROUND_ROBIN_EN
              d = (c - last_m[b] - 1 + 2*N) % N;
`else
              d = c;
`endif
              if (d < bestd) begin bestd = d; best = c; end
            end
          end
          if (best >= 0) begin
            e_grant[best]          = 1'b1;
            e_cen[b]               = 1'b1;
            e_we[b]                = bus.wr[best];
            e_addr[b*AW +: AW]     = bus.addr[best*AW +: AW];
            e_wdata[b*DW +: DW]    = bus.wdata[best*DW +: DW];
            if (bus.wr[best])
              mir[b][bus.addr[best*AW +: 10]] = bus.wdata[best*DW +: DW];
            else
              pend.push_back('{due: cyc + L, cli: best, data: mir[b][bus.addr[best*AW +: 10]]});
            last_m[b] = best;
          end
        end
      end
      for (int c = 0; c < N; c++) e_rdata[c*DW +: DW] = held_m[c];
      check("grant",     bus.grant,     e_grant);
      check("mem_cen",   bus.mem_cen,   e_cen);
      check("mem_we",    bus.mem_we,    e_we);
      check("mem_addr",  bus.mem_addr,  e_addr);
      check("mem_wdata", bus.mem_wdata, e_wdata);
      check("rvalid",    bus.rvalid,    e_rvalid);
      check("rdata",     bus.rdata,     e_rdata);
    end
  end

  task automatic set_cli(input int c, input logic r, input logic w, input int b,
                         input logic [AW-1:0] a, input logic [DW-1:0] dat);
    bus.req[c]            = r;
    bus.wr[c]             = w;
    bus.bank[c*LB +: LB]  = LB'(b);
    bus.addr[c*AW +: AW]  = a;
    bus.wdata[c*DW +: DW] = dat;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Directed stimulus with hand-computed literal expectations
  initial begin
    logic [N-1:0]  exp_g;
    logic [DW-1:0] exp_d;
    bus.req = '0; bus.wr = '0; bus.bank = '0; bus.addr = '0; bus.wdata = '0;
    for (int b = 0; b < M; b++) begin
      for (int a = 0; a < 1024; a++) begin
        sram[b][a] = init_word(b, a);
        mir[b][a]  = init_word(b, a);
      end
      for (int s = 0; s < 8; s++) begin
        slot_v[b][s] = 1'b0;
        slot_d[b][s] = '0;
      end
    end
    sram[1][10'h100] = 36'h123456789;
    mir[1][10'h100]  = 36'h123456789;

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    set_cli(1, 1'b1, 1'b0, 0, 19'h3, '0);
    @(negedge clock);
    check("lit_reset_grant",  bus.grant,   4'b0000);
    check("lit_reset_cen",    bus.mem_cen, 2'b00);
    check("lit_reset_rvalid", bus.rvalid,  4'b0000);
    check("lit_reset_rdata",  bus.rdata,   '0);
    step();
    set_cli(1, 1'b0, 1'b0, 0, '0, '0);
    reset = 1'b0;
    step();

    // Single read: client 2, bank 1, addr 0x100
    set_cli(2, 1'b1, 1'b0, 1, 19'h00100, '0);
    @(negedge clock);
    check("lit_single_grant", bus.grant, 4'b0100);
    check("lit_single_cen",   bus.mem_cen, 2'b10);
    check("lit_single_addr",  bus.mem_addr[AW +: AW], 19'h00100);
    step();
    set_cli(2, 1'b0, 1'b0, 0, '0, '0);
    step();
    @(negedge clock);
    check("lit_single_rvalid", bus.rvalid, 4'b0100);
    check("lit_single_rdata",  bus.rdata[2*DW +: DW], 36'h123456789);
    step();
    @(negedge clock);
    check("lit_single_rvalid_off", bus.rvalid, 4'b0000);
    check("lit_single_rdata_held", bus.rdata[2*DW +: DW], 36'h123456789);
    step();

    // Contention on bank 0 from clients 0, 1, 3
    set_cli(0, 1'b1, 1'b0, 0, 19'h10, '0);
    set_cli(1, 1'b1, 1'b0, 0, 19'h11, '0);
    set_cli(3, 1'b1, 1'b0, 0, 19'h13, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = (i % 3 == 0) ? 4'b0001 : ((i % 3 == 1) ? 4'b0010 : 4'b1000);
`else
      exp_g = 4'b0001;
`endif
      check("lit_contention_grant", bus.grant, exp_g);
      step();
    end
    bus.req = '0;
    repeat (3) step();

    // Parallel banks: write on bank 0, read on bank 1, same cycle
    set_cli(0, 1'b1, 1'b1, 0, 19'h5, 36'hAAAA);
    set_cli(1, 1'b1, 1'b0, 1, 19'h5, '0);
    @(negedge clock);
    check("lit_parallel_grant", bus.grant,   4'b0011);
    check("lit_parallel_cen",   bus.mem_cen, 2'b11);
    check("lit_parallel_we",    bus.mem_we,  2'b01);
    step();
    bus.req = '0;
    step();
    @(negedge clock);
    check("lit_parallel_rvalid", bus.rvalid, 4'b0010);
    check("lit_parallel_rdata",  bus.rdata[DW +: DW], 36'h0_0100_1005);
    step();
    set_cli(0, 1'b1, 1'b0, 0, 19'h5, '0);
    step();
    bus.req = '0;
    step();
    @(negedge clock);
    check("lit_readback_rvalid", bus.rvalid, 4'b0001);
    check("lit_readback_rdata",  bus.rdata[0 +: DW], 36'hAAAA);
    step();

    // Back-to-back reads: client 3, bank 0, addresses 0..7
    for (int i = 0; i < 11; i++) begin
      if (i < 8) set_cli(3, 1'b1, 1'b0, 0, AW'(i), '0);
      else       set_cli(3, 1'b0, 1'b0, 0, '0, '0);
      @(negedge clock);
      if (i >= 2 && i < 10) begin
        exp_d = (i - 2 == 5) ? 36'hAAAA : 36'h1000 + DW'(i - 2);
        check("lit_b2b_rvalid", bus.rvalid[3], 1'b1);
        check("lit_b2b_rdata",  bus.rdata[3*DW +: DW], exp_d);
      end else begin
        check("lit_b2b_rvalid_idle", bus.rvalid[3], 1'b0);
      end
      step();
    end

    // Reset while a read is in flight
    set_cli(1, 1'b1, 1'b0, 1, 19'h7, '0);
    @(negedge clock);
    check("lit_midreset_grant", bus.grant, 4'b0010);
    step();
    bus.req = '0;
    reset = 1'b1;
    @(negedge clock);
    check("lit_midreset_cen",    bus.mem_cen, 2'b00);
    check("lit_midreset_rvalid", bus.rvalid,  4'b0000);
    step();
    reset = 1'b0;
    @(negedge clock);
    check("lit_midreset_norv", bus.rvalid, 4'b0000);
    check("lit_midreset_rdata", bus.rdata, '0);
    step();
    @(negedge clock);
    check("lit_midreset_norv2", bus.rvalid, 4'b0000);
    step();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_bank_arbiter.md
# sram_bank_arbiter

Parametrised N-client, M-bank SRAM arbiter with tagged read-return pipelines; next-generation replacement for the fixed 4-client/2-bank ZBT access logic. Each cycle, for every bank it grants at most one requesting client, drives that bank's address/data/write-enable, and routes returned read data back to the originating client after a configurable read latency. Sits between pixel-stream clients (NTSC capture, VGA, LPF, projective fetch) and the `zbt_6111` wrappers in the top module.

## Interface
- NUM_CLIENTS, 4, number of requesting clients (2..8); index 0 is highest fixed priority
- NUM_BANKS, 2, number of SRAM banks (1..4)
- LOG_BANKS, 1, width of bank select; ceil(log2(NUM_BANKS)), minimum 1
- ADDR_W, 19, SRAM word address width
- DATA_W, 36, SRAM data width
- READ_LAT, 2, cycles from address cycle to valid `mem_rdata` (1..4)

- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req  in  NUM_CLIENTS  per-client access request, level
- wr  in  NUM_CLIENTS  per-client write (1) / read (0)
- bank  in  NUM_CLIENTS*LOG_BANKS  per-client target bank, packed, client 0 in LSBs
- addr  in  NUM_CLIENTS*ADDR_W  per-client word address, packed
- wdata  in  NUM_CLIENTS*DATA_W  per-client write data, packed
- grant  out  NUM_CLIENTS  access accepted this cycle (combinational)
- rvalid  out  NUM_CLIENTS  read data for client valid this cycle
- rdata  out  NUM_CLIENTS*DATA_W  per-client read data, held between returns
- mem_cen  out  NUM_BANKS  bank cycle enable
- mem_we  out  NUM_BANKS  bank write enable
- mem_addr  out  NUM_BANKS*ADDR_W  bank address
- mem_wdata  out  NUM_BANKS*DATA_W  bank write data
- mem_rdata  in  NUM_BANKS*DATA_W  bank read data

## Operation
- Per bank b: candidates = clients with `req` high and `bank`==b. Bank values >= NUM_BANKS never granted.
- Exactly one candidate granted per bank per cycle; client receives at most one grant per cycle (one bank target).
- Granted bank: `mem_cen[b]`=1, `mem_we[b]`=`wr[c]`, `mem_addr`/`mem_wdata` = client's fields. Idle bank: cen=0, we=0, addr=0, wdata=0.
- Ungranted client keeps `req` and fields stable until granted; no request queuing inside the block.
- Tag pipeline per bank, READ_LAT stages, each {valid, client index}. Stage 0 loads {1, c} on granted read, {0, x} otherwise; shifts every cycle.
- At final stage valid with client c: `rvalid[c]`=1, `rdata[c]`=bank's `mem_rdata` (combinational pass-through); registered copy captured for hold.
- Otherwise `rdata[c]` = last captured value; `rvalid[c]`=0.
- Writes never enter the tag pipeline.

## Timing
- grant and mem_* outputs combinational from req/wr/bank/addr/wdata and arbitration state; zero-cycle grant.
- Read issued in cycle T returns `rvalid` in cycle T+READ_LAT; back-to-back reads on one bank return in issue order, one per cycle.
- Reset: all arbitration pointers -> NUM_CLIENTS-1 (so client 0 first), tag pipelines cleared, held rdata=0, `rvalid`=0, `grant`=0, all mem_cen/we=0 while reset high.
- Reset mid-operation: in-flight reads discarded; no `rvalid` for them after reset deasserts.
- Simultaneous read return and new grant for same client on same or different bank: both honoured; at most one return per client per cycle (guaranteed by one-grant-per-cycle rule and equal latency).

## Configuration
- ARB_ROUND_ROBIN_EN defined: per-bank round-robin. Register `last[b]` holds last granted client; search starts at `last[b]+1` mod NUM_CLIENTS; `last[b]` updates only on cycles bank b grants.
- Undefined: fixed priority, lowest client index wins; `last` registers not implemented.

## Test plan
- Single read: client 2 reads bank 1 addr 0x00100, model returns 0x123456789 after READ_LAT=2 -> grant[2] same cycle, mem_cen[1]=1, rvalid[2] and rdata=0x123456789 at T+2, rdata held after.
- Contention, fixed priority: clients 0,1,3 all request bank 0 continuously -> client 0 granted every cycle, 1 and 3 starved, grant stable.
- Contention, ARB_ROUND_ROBIN_EN: same stimulus -> grant sequence 0,1,3,0,1,3 from reset.
- Parallel banks: client 0 writes 0xAAAA to bank 0 addr 5, client 1 reads bank 1 addr 5, same cycle -> both granted; only rvalid[1] at T+2.
- Back-to-back reads: client 3 reads bank 0 addrs 0..7 consecutively -> eight consecutive rvalid[3] cycles, data in address order.
- Reset mid-flight: read issued, reset asserted next cycle for 1 cycle -> no rvalid, rdata=0, mem_cen=0 during reset.
